// File: rtl/div_16by8.sv
// div_16by8: sequential restoring divider, 16-bit unsigned dividend by
// 8-bit unsigned divisor, one quotient bit per clock, MSB first.
//
// state | meaning
// IDLE  | waiting for start; quot/rem/div_zero hold the last result
// CALC  | one restoring iteration per cycle, 16 cycles
// DONE  | publish result, pulse done next cycle, return to IDLE

module div_16by8 #(
  parameter int DW_X = 16,
  parameter int DW_Y = 8
) (
  input  logic            CLK_50M,
  input  logic            rst,
  input  logic            start,
  input  logic [DW_X-1:0] x,
  input  logic [DW_Y-1:0] y,
  output logic [DW_X-1:0] quot,
  output logic [DW_Y-1:0] rem,
  output logic            busy,
  output logic            done,
  output logic            div_zero
);

  localparam int CW = $clog2(DW_X);
  localparam int RW = DW_Y + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW_X-1:0] q_q, q_d;
  logic [DW_Y-1:0] dvs_q, dvs_d;
  logic [RW-1:0]   r_q, r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW_X-1:0] quot_q, quot_d;
  logic [DW_Y-1:0] rem_q, rem_d;
  logic            done_q, done_d;
  logic            div_zero_q, div_zero_d;
  logic            accept;
  logic [RW:0]     trial;

  // The result-pulse cycle still counts as busy, so a start arriving there
  // is held off and a continuous start relaunches on the following edge.
  assign accept = (state_q == IDLE) && start && !done_q;
  assign trial  = {r_q, q_q[DW_X-1]};

  // State register
  always_ff @(posedge CLK_50M or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: a zero divisor skips the iterations entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (y == '0) ? DONE : CALC;
      CALC:    if (cnt_q == CW'(DW_X - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working registers: capture operands on accept, one restoring step per CALC cycle
  always_comb begin
    q_d   = q_q;
    dvs_d = dvs_q;
    r_d   = r_q;
    cnt_d = cnt_q;
    if (accept) begin
      q_d   = x;
      dvs_d = y;
      r_d   = '0;
      cnt_d = '0;
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + CW'(1);
      if (trial >= {2'b00, dvs_q}) begin
        r_d = RW'(trial - {2'b00, dvs_q});
        q_d = {q_q[DW_X-2:0], 1'b1};
      end else begin
        r_d = RW'(trial);
        q_d = {q_q[DW_X-2:0], 1'b0};
      end
    end
  end

  // Outputs: results update only when leaving DONE, otherwise hold
  always_comb begin
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;
    if (state_q == DONE) begin
      done_d = 1'b1;
      if (dvs_q == '0) begin
        quot_d     = '1;
        rem_d      = q_q[DW_Y-1:0];
        div_zero_d = 1'b1;
      end else begin
        quot_d     = q_q;
        rem_d      = r_q[DW_Y-1:0];
        div_zero_d = 1'b0;
      end
    end
  end

  // Working and result registers
  always_ff @(posedge CLK_50M or posedge rst) begin
    if (rst) begin
      q_q        <= '0;
      dvs_q      <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      dvs_q      <= dvs_d;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign quot     = quot_q;
  assign rem      = rem_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign busy     = (state_q != IDLE) || done_q;

endmodule

// File: doc/div_16by8.md
DIV_16BY8 -- requirements
Module: div_16by8

Interface
REQ-001 The block SHALL have parameter DW_X, default 16, meaning the dividend width; DW_Y, default 8, meaning the divisor width. Both are fixed at these values for this release.
REQ-002 The block SHALL have the port CLK_50M, input, 1 bit, the single system clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit, an asynchronous active-high reset.
REQ-004 The block SHALL have the port start, input, 1 bit, a request to begin one division.
REQ-005 The block SHALL have the port x, input, 16 bits, the unsigned dividend, sampled only when a start is accepted.
REQ-006 The block SHALL have the port y, input, 8 bits, the unsigned divisor, sampled only when a start is accepted.
REQ-007 The block SHALL have the port quot, output reg, 16 bits, the unsigned quotient.
REQ-008 The block SHALL have the port rem, output reg, 8 bits, the unsigned remainder.
REQ-009 The block SHALL have the port busy, output, 1 bit, which is high whenever the FSM is not in IDLE.
REQ-010 The block SHALL have the port done, output reg, 1 bit, a one-cycle pulse indicating that quot/rem are valid.
REQ-011 The block SHALL have the port div_zero, output reg, 1 bit, which is set with done when y was 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE, encoded in 2 bits.
REQ-013 In IDLE with start=1 at a clock edge, the block SHALL latch x into a 16-bit working quotient register and y into a divisor register, clear a 9-bit partial remainder and a 4-bit iteration counter, and go to CALC.
REQ-014 The iteration in REQ-015 SHALL be restoring: each CALC cycle performs one iteration, MSB first.
REQ-015 Each iteration SHALL form t = {r[7:0], q[15]} and shift q left by 1. If t >= {1'b0, divisor}, then r = t - divisor and q[0] = 1; otherwise r = t and q[0] = 0.
REQ-016 On the CALC cycle with counter == 15, the FSM SHALL go to DONE. CALC therefore lasts exactly 16 cycles.
REQ-017 In DONE, the block SHALL load quot with q and rem with r[7:0], assert done=1 and div_zero=0, and return to IDLE.
REQ-018 Latency: with start accepted at edge k, done SHALL be high for the single cycle following edge k+17.
REQ-019 Divide-by-zero: if y == 0 at acceptance, the block SHALL bypass CALC and go directly to DONE. It SHALL then produce quot = 16'hFFFF, rem = x[7:0], div_zero = 1, and done after edge k+1 (latency 2).
REQ-020 start SHALL be ignored while busy=1, including during DONE; no queuing.
REQ-021 start held high continuously SHALL launch a new division on the first IDLE cycle after done.
REQ-022 quot, rem and div_zero SHALL hold their values from done until the next done; x/y changes during CALC SHALL NOT affect the result.
REQ-023 done SHALL be low in every cycle other than the one specified in REQ-018/REQ-019.
REQ-024 The result SHALL satisfy x == quot*y + rem and rem < y for all y != 0, with no overflow (the quotient always fits in 16 bits).

Reset
REQ-025 While rst=1, the block SHALL force, asynchronously: state = IDLE, quot = 0, rem = 0, done = 0, div_zero = 0, busy = 0, and all working registers and the counter = 0.
REQ-026 A reset asserted mid-CALC or in DONE SHALL abort the operation; no done pulse SHALL be produced for that operation.
REQ-027 After rst deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-028 The bench SHALL apply x = 1000, y = 7, start at edge k -> done after edge k+17, quot = 142, rem = 6, div_zero = 0.
REQ-029 The bench SHALL apply x = 16'hFFFF, y = 1 -> quot = 16'hFFFF, rem = 0; then x = 16'hFFFF, y = 8'hFF -> quot = 257, rem = 0.
REQ-030 The bench SHALL apply x = 16'h04D2, y = 0 -> done after edge k+1, quot = 16'hFFFF, rem = 8'hD2, div_zero = 1; then x = 5, y = 10 -> quot = 0, rem = 5, div_zero = 0.
REQ-031 The bench SHALL issue x = 100, y = 3, then pulse start with x = 50, y = 5 at edge k+5 -> only one done, quot = 33, rem = 1.
REQ-032 The bench SHALL assert rst at edge k+8 of a division -> all outputs become 0 immediately and no done follows. After release, x = 200, y = 9 -> quot = 22, rem = 2.
REQ-033 The bench SHALL run a random regression of at least 10000 (x, y != 0) pairs and check REQ-024 at every done, and check that busy is high for exactly 18 cycles per operation.
